// File: rtl/wb_dual_master_arbiter.sv
// Round-robin share of one Wishbone-classic slave between fetch (m0) and data (m1); ARB_TIMEOUT_EN adds an s_ack watchdog.
// Latency: a request seen in IDLE is on the slave bus next cycle; acks and read data pass through combinationally.
// Backpressure: the losing master waits with ack low until the current grant ends by ack, abort or timeout.
module wb_dual_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_ack,
  output logic [1:0]              grant_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   req0, req1, to_hit, grant_end, abort;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  function automatic state_t arbitrate(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return last ? GNT0 : GNT1;
    else if (r0)  return GNT0;
    else if (r1)  return GNT1;
    else          return IDLE;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // An ack landing on the limit cycle wins over the timeout.
  assign to_hit = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES)) && !s_ack;
  assign cnt_d  = (state_q != IDLE && !grant_end && !abort) ? cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    grant_end = 1'b0;
    abort     = 1'b0;
    if (state_q == GNT0) begin
      grant_end = req0 & (s_ack | to_hit);
      abort     = ~req0;
    end else if (state_q == GNT1) begin
      grant_end = req1 & (s_ack | to_hit);
      abort     = ~req1;
    end
  end

  always_comb begin
    last_d  = last_q;
    state_d = state_q;
    if (grant_end) last_d = (state_q == GNT1);
    if (state_q == IDLE || grant_end) state_d = arbitrate(req0, req1, last_d);
    else if (abort)                   state_d = IDLE;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_sel     = '0;
    s_addr    = '0;
    s_data_o  = '0;
    grant_o   = 2'b00;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    m0_data_o = s_data_i;
    m1_data_o = s_data_i;
    case (state_q)
      GNT0: begin
        s_cyc    = m0_cyc & ~to_hit;
        s_stb    = m0_stb & ~to_hit;
        s_we     = m0_we;
        s_sel    = m0_sel;
        s_addr   = m0_addr;
        s_data_o = m0_data_i;
        grant_o  = 2'b01;
        m0_ack   = s_ack & req0;
        m0_err   = to_hit & req0;
      end
      GNT1: begin
        s_cyc    = m1_cyc & ~to_hit;
        s_stb    = m1_stb & ~to_hit;
        s_we     = m1_we;
        s_sel    = m1_sel;
        s_addr   = m1_addr;
        s_data_o = m1_data_i;
        grant_o  = 2'b10;
        m1_ack   = s_ack & req1;
        m1_err   = to_hit & req1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for wb_dual_master_arbiter: reset, read, round-robin, write, abort, spurious ack, timeout.
module tb_wb_dual_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          sys_clk, rst_n;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [SW-1:0] m0_sel, m1_sel, s_sel;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_data_i, m0_data_o, m1_data_i, m1_data_o, s_data_o, s_data_i;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [1:0]    grant_o;

  int errors = 0;
  int checks = 0;

  wb_dual_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack(s_ack), .grant_o(grant_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1ns after the edge; checks happen 2ns later, well before the next edge.
  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic m0_drive(input logic cyc, input logic stb, input logic we,
                          input logic [SW-1:0] sel, input logic [AW-1:0] addr, input logic [DW-1:0] dat);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_sel = sel; m0_addr = addr; m0_data_i = dat;
  endtask

  task automatic m1_drive(input logic cyc, input logic stb, input logic we,
                          input logic [SW-1:0] sel, input logic [AW-1:0] addr, input logic [DW-1:0] dat);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_sel = sel; m1_addr = addr; m1_data_i = dat;
  endtask

  initial begin
    rst_n = 1'b0; s_ack = 1'b0; s_data_i = '0;
    m0_drive(1, 1, 0, 4'hf, 32'h10, 32'h0);
    m1_drive(1, 1, 0, 4'hf, 32'h14, 32'h0);

    // Reset with both masters requesting
    tick; tick; #2;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    rst_n = 1'b1;
    tick; #2;
    chk("post_rst_grant", grant_o, 2'b01);
    chk("post_rst_addr", s_addr, 32'h10);
    m0_drive(0, 0, 0, 0, 0, 0);
    m1_drive(0, 0, 0, 0, 0, 0);
    #2 chk("post_rst_abort_ack", m0_ack, 0);
    tick; #2 chk("post_rst_idle", grant_o, 2'b00);

    // Single read by m1 with two wait states
    m1_drive(1, 1, 0, 4'hf, 32'h0000_0100, 32'h0);
    #2;
    chk("rd_t_grant", grant_o, 2'b00);
    chk("rd_t_cyc", s_cyc, 0);
    tick; #2;
    chk("rd_t1_grant", grant_o, 2'b10);
    chk("rd_t1_cyc", s_cyc, 1);
    chk("rd_t1_stb", s_stb, 1);
    chk("rd_t1_addr", s_addr, 32'h100);
    chk("rd_t1_we", s_we, 0);
    chk("rd_t1_ack", m1_ack, 0);
    tick; #2;
    chk("rd_t2_ack", m1_ack, 0);
    chk("rd_t2_addr", s_addr, 32'h100);
    tick;
    s_ack = 1'b1; s_data_i = 32'hDEAD_BEEF;
    #2;
    chk("rd_t3_m1_ack", m1_ack, 1);
    chk("rd_t3_data", m1_data_o, 32'hDEAD_BEEF);
    chk("rd_t3_m0_ack", m0_ack, 0);
    tick;
    m1_drive(0, 0, 0, 0, 0, 0); s_ack = 1'b0;
    #2 chk("rd_t4_ack", m1_ack, 0);
    tick; #2 chk("rd_idle", grant_o, 2'b00);

    // Contention, zero-wait slave; s_ack in IDLE must not leak
    m0_drive(1, 1, 0, 4'hf, 32'h200, 32'h0);
    m1_drive(1, 1, 0, 4'hf, 32'h300, 32'h0);
    s_ack = 1'b1;
    #2;
    chk("rr_idle_m0_ack", m0_ack, 0);
    chk("rr_idle_m1_ack", m1_ack, 0);
    for (int i = 0; i < 4; i++) begin
      tick; #2;
      chk("rr_grant", grant_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_m0_ack", m0_ack, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("rr_m1_ack", m1_ack, (i % 2 == 0) ? 1'b0 : 1'b1);
      chk("rr_addr", s_addr, (i % 2 == 0) ? 32'h200 : 32'h300);
    end
    tick;
    m0_drive(0, 0, 0, 0, 0, 0);
    m1_drive(0, 0, 0, 0, 0, 0);
    s_ack = 1'b0;
    #2 chk("rr_end_ack", m0_ack | m1_ack, 0);
    tick; #2 chk("rr_idle", grant_o, 2'b00);

    // Write pass-through from m0
    m0_drive(1, 1, 1, 4'b0011, 32'h20, 32'h1234_5678);
    tick; #2;
    chk("wr_grant", grant_o, 2'b01);
    chk("wr_we", s_we, 1);
    chk("wr_sel", s_sel, 4'b0011);
    chk("wr_data", s_data_o, 32'h1234_5678);
    chk("wr_addr", s_addr, 32'h20);
    chk("wr_ack_wait", m0_ack, 0);
    tick;
    s_ack = 1'b1;
    #2;
    chk("wr_ack", m0_ack, 1);
    chk("wr_m1_ack", m1_ack, 0);
    tick;
    m0_drive(0, 0, 0, 0, 0, 0); s_ack = 1'b0;
    #2 chk("wr_after_ack", m0_ack, 0);
    tick; #2;
    chk("wr_idle", grant_o, 2'b00);
    chk("wr_idle_cyc", s_cyc, 0);

    // Abort: m0 drops stb while waiting
    m0_drive(1, 1, 0, 4'hf, 32'h40, 32'h0);
    tick; #2 chk("ab_grant", grant_o, 2'b01);
    tick;
    m0_stb = 1'b0;
    #2 chk("ab_ack", m0_ack, 0);
    tick;
    m0_cyc = 1'b0;
    #2 chk("ab_idle", grant_o, 2'b00);

    // Spurious ack in IDLE
    s_ack = 1'b1;
    #2;
    chk("sp_m0_ack", m0_ack, 0);
    chk("sp_m1_ack", m1_ack, 0);
    chk("sp_cyc", s_cyc, 0);
    tick;
    s_ack = 1'b0;

    // Slave never acks m1; m0 waits
    m1_drive(1, 1, 0, 4'hf, 32'h80, 32'h0);
    tick; #2;
    chk("to_g_grant", grant_o, 2'b10);
    chk("to_g_err", m1_err, 0);
    for (int k = 1; k < 4; k++) begin
      tick;
      m0_drive(1, 1, 0, 4'hf, 32'h44, 32'h0);
      #2;
      chk("to_wait_err", m1_err, 0);
      chk("to_wait_grant", grant_o, 2'b10);
    end
    tick; #2;
`ifdef ARB_TIMEOUT_EN
    chk("to_err", m1_err, 1);
    chk("to_ack", m1_ack, 0);
    chk("to_cyc", s_cyc, 0);
    tick; #2;
    chk("to_next_grant", grant_o, 2'b01);
    chk("to_err_once", m1_err, 0);
`else
    chk("to_err", m1_err, 0);
    chk("to_grant", grant_o, 2'b10);
    chk("to_cyc", s_cyc, 1);
    tick; #2;
    chk("to_still_grant", grant_o, 2'b10);
    chk("to_m0_err", m0_err, 0);
`endif
    m0_drive(0, 0, 0, 0, 0, 0);
    m1_drive(0, 0, 0, 0, 0, 0);
    tick; tick; #2;
    chk("final_idle", grant_o, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
- Shares one Wishbone-classic slave port (memory / Controller bus) between two masters: m0 = instruction fetch, m1 = data access.
- Sits between the processor core's bus ports and the memory/Controller whenever a core exposes split buses but only one memory is instantiated.
- Round-robin arbitration, one transfer per grant; the slave side carries exactly one master's signals at a time.

Parameters:
ADDR_WIDTH, 32, address width of masters and slave
DATA_WIDTH, 32, data width; SEL width = DATA_WIDTH/8
TIMEOUT_CYCLES, 255, max wait for s_ack per grant (used only with ARB_TIMEOUT_EN)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle/strobe/write
m0_sel  in  SEL  master 0 byte selects
m0_addr  in  ADDR_WIDTH  master 0 address
m0_data_i  in  DATA_WIDTH  master 0 write data
m0_data_o  out  DATA_WIDTH  master 0 read data
m0_ack  out  1  master 0 acknowledge
m0_err  out  1  master 0 bus error (timeout)
m1_*  same set as m0_* for master 1
s_cyc, s_stb, s_we  out  1 each  slave cycle/strobe/write
s_sel  out  SEL  slave byte selects
s_addr  out  ADDR_WIDTH  slave address
s_data_o  out  DATA_WIDTH  slave write data
s_data_i  in  DATA_WIDTH  slave read data
s_ack  in  1  slave acknowledge
grant_o  out  2  one-hot current owner {m1,m0}; 00 when idle

Behaviour:
- Request: mN_req = mN_cyc & mN_stb.
- FSM states: IDLE, GNT0, GNT1. State and last-grant pointer `last` are registered; slave outputs are a combinational mux of the granted master. Acks are combinational pass-through from s_ack.
- Reset (rst_n low at a clock edge): state = IDLE, last = 1 (m0 wins first), timeout counter = 0.
- IDLE outputs: s_cyc, s_stb, s_we = 0; s_sel, s_addr, s_data_o = 0; grant_o = 00; m*_ack = m*_err = 0.
- Arbitration, evaluated in IDLE and in any cycle where the current grant ends:
  - Both masters requesting: grant the master != last.
  - One master requesting: grant it.
  - Neither requesting: go to IDLE.
  - The new grant takes effect next cycle.
- Latency: request first seen in IDLE at cycle t gives s_cyc=s_stb=1 at t+1. With a zero-wait slave (s_ack at t+1), mN_ack is high at t+1.
- GNTn:
  - s_* = mN_*; grant_o one-hot for N.
  - mN_ack = s_ack; the other master's ack/err = 0.
  - Both m*_data_o = s_data_i (broadcast; only meaningful with ack).
- End of grant:
  - s_ack=1 in GNTn: last <= N; re-arbitrate in the same cycle, so back-to-back transfers to the other master incur no idle cycle. A master holding stb high after its ack makes a new request.
  - Granted master drops stb or cyc before ack: abort. Go to IDLE next cycle, no ack forwarded, last unchanged.
- s_ack while IDLE: ignored, not forwarded.
- Non-granted master: held off indefinitely (ack=0). Masters hold their signals stable until ack, per Wishbone classic.
- Reset mid-transfer: the pending transfer is dropped silently; no ack/err issued.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to GNTn and increments each cycle without s_ack.
  - When the counter reaches TIMEOUT_CYCLES, assert mN_err for one cycle (ack stays 0), force s_cyc=s_stb=0 that cycle, set last <= N, and re-arbitrate.
  - The counter width is derived from TIMEOUT_CYCLES.
- Not defined: no counter; grants wait indefinitely for s_ack; m0_err = m1_err = 0 constant.

Test Plan:
- Reset check: hold rst_n=0 for 2 clocks with both masters requesting -> all s_* = 0, grant_o=00, acks=0. Release -> grant_o=01 next cycle.
- Single read: m1 reads addr 0x0000_0100, slave acks after 2 wait states with s_data_i=0xDEAD_BEEF -> s_addr=0x100 and s_we=0 from t+1. m1_ack high exactly 1 cycle at t+3 with m1_data_o=0xDEADBEEF; m0_ack stays 0.
- Contention round-robin: both masters request continuously, zero-wait slave -> grants alternate 01,10,01,10 with no idle cycle between. Each master gets one ack every 2 cycles.
- Write pass-through: m0 writes 0x1234_5678, sel=0011, addr 0x20 -> s_we=1, s_sel=0011, s_data_o=0x12345678 while granted. m0_ack mirrors s_ack.
- Abort/spurious ack: m0 drops stb during wait states -> IDLE next cycle, no ack. s_ack pulsed in IDLE -> no master ack.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4: slave never acks m1 -> m1_err high 1 cycle, 4 cycles after grant. A waiting m0 is granted the following cycle. Without the macro, m1 stays granted and m1_err=0.
